// File: rtl/rr_arbiter_n_if.sv
// rtl/rr_arbiter_n_if.sv - request/grant bundle between crossbar masters and one slave arbiter
interface rr_arbiter_n_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 2,
  parameter int IDX_W     = $clog2(N_MASTERS) + 1
);
  logic [N_MASTERS-1:0]        master_req;
  logic [N_MASTERS*ADDR_W-1:0] master_addr;
  logic                        slave_ack;
  logic [IDX_W-1:0]            number_master_en;
  logic                        slave_req;
  logic [N_MASTERS-1:0]        master_ack;
  logic                        busy;

  modport master (
    output master_req, master_addr, slave_ack,
    input  number_master_en, slave_req, master_ack, busy
  );

  modport slave (
    input  master_req, master_addr, slave_ack,
    output number_master_en, slave_req, master_ack, busy
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin arbiter for one crossbar slave port
// Rotating-pointer grant with per-grant burst quota; grant held while the master keeps requesting.
module rr_arbiter_n #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 2,
  parameter int SLAVE     = 0,
  parameter int BURST_MAX = 1,
  parameter int IDX_W     = $clog2(N_MASTERS) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  rr_arbiter_n_if.slave  bus
);
  localparam int                PTR_W     = $clog2(N_MASTERS);
  localparam int                POS_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] SLAVE_SEL = ADDR_W'(SLAVE);
  localparam logic [8:0]        BURST_LIM = 9'(BURST_MAX);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_MASTERS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     grant_idx_q, grant_idx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [N_MASTERS-1:0] elig;
  logic                 cur_elig;
  logic [8:0]           burst_next;
  logic [PTR_W-1:0]     after_grant;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_elig
    assign elig[g] = bus.master_req[g] && (bus.master_addr[g*ADDR_W +: ADDR_W] == SLAVE_SEL);
  end

  assign cur_elig    = elig[grant_idx_q];
  assign burst_next  = {1'b0, burst_cnt_q} + 9'd1;
  assign after_grant = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + PTR_W'(1);

  // Scanning a doubled request vector avoids a modulo for non-power-of-2 master counts.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_MASTERS-1:0] cand,
                                               input logic [PTR_W-1:0] start);
    logic [2*N_MASTERS-1:0] dbl;
    logic [POS_W-1:0]       pos;
    logic [PTR_W-1:0]       pick;
    logic                   found;
    dbl   = {cand, cand};
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      pos = {1'b0, start} + POS_W'(k);
      if (!found && dbl[pos]) begin
        found = 1'b1;
        pick  = (pos >= POS_W'(N_MASTERS)) ? PTR_W'(pos - POS_W'(N_MASTERS)) : pos[PTR_W-1:0];
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d     = ST_GRANT;
          grant_idx_d = rr_pick(elig, ptr_q);
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!cur_elig) begin
          state_d     = ST_IDLE;
          ptr_d       = after_grant;
          burst_cnt_d = '0;
        end else if (bus.slave_ack) begin
          if (burst_next < BURST_LIM) begin
            burst_cnt_d = burst_next[7:0];
          end else begin
            // The outgoing holder is last in scan order, so it only wins again when alone.
            ptr_d       = after_grant;
            grant_idx_d = rr_pick(elig, after_grant);
            burst_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.number_master_en = '0;
    bus.slave_req        = 1'b0;
    bus.master_ack       = '0;
    bus.busy             = 1'b0;
    if (state_q == ST_GRANT) begin
      bus.busy             = 1'b1;
      bus.slave_req        = cur_elig;
      bus.number_master_en = IDX_W'(grant_idx_q) + IDX_W'(1);
      if (cur_elig && bus.slave_ack) begin
        bus.master_ack = N_MASTERS'(1) << grant_idx_q;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - randomized and directed bench for rr_arbiter_n against a behavioural model
module tb_rr_arbiter_n;
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] req  [3];
  logic [3:0]  addr [3][16];
  logic        ack  [3];

  int          nme_v  [3];
  logic        sreq_v [3];
  logic [15:0] mack_v [3];
  logic        busy_v [3];

  int n_checks = 0;
  int n_errors = 0;

  int mn  [3] = '{4, 4, 5};
  int mb  [3] = '{1, 3, 1};
  int ms  [3] = '{0, 0, 5};
  int maw [3] = '{2, 2, 3};

  int mg [3] = '{-1, -1, -1};
  int mp [3] = '{0, 0, 0};
  int mc [3] = '{0, 0, 0};
  int ng [3];
  int np [3];
  int nc [3];

  rr_arbiter_n_if #(.N_MASTERS(4), .ADDR_W(2)) if_a ();
  rr_arbiter_n_if #(.N_MASTERS(4), .ADDR_W(2)) if_b ();
  rr_arbiter_n_if #(.N_MASTERS(5), .ADDR_W(3)) if_c ();

  rr_arbiter_n #(.N_MASTERS(4), .ADDR_W(2), .SLAVE(0), .BURST_MAX(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  rr_arbiter_n #(.N_MASTERS(4), .ADDR_W(2), .SLAVE(0), .BURST_MAX(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  rr_arbiter_n #(.N_MASTERS(5), .ADDR_W(3), .SLAVE(5), .BURST_MAX(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  always_comb begin
    if_a.master_req  = req[0][3:0];
    if_a.slave_ack   = ack[0];
    if_a.master_addr = '0;
    for (int i = 0; i < 4; i++) if_a.master_addr[i*2 +: 2] = addr[0][i[3:0]][1:0];
  end
  always_comb begin
    if_b.master_req  = req[1][3:0];
    if_b.slave_ack   = ack[1];
    if_b.master_addr = '0;
    for (int i = 0; i < 4; i++) if_b.master_addr[i*2 +: 2] = addr[1][i[3:0]][1:0];
  end
  always_comb begin
    if_c.master_req  = req[2][4:0];
    if_c.slave_ack   = ack[2];
    if_c.master_addr = '0;
    for (int i = 0; i < 5; i++) if_c.master_addr[i*3 +: 3] = addr[2][i[3:0]][2:0];
  end

  assign nme_v[0]  = int'(if_a.number_master_en);
  assign nme_v[1]  = int'(if_b.number_master_en);
  assign nme_v[2]  = int'(if_c.number_master_en);
  assign sreq_v[0] = if_a.slave_req;
  assign sreq_v[1] = if_b.slave_req;
  assign sreq_v[2] = if_c.slave_req;
  assign mack_v[0] = 16'(if_a.master_ack);
  assign mack_v[1] = 16'(if_b.master_ack);
  assign mack_v[2] = 16'(if_c.master_ack);
  assign busy_v[0] = if_a.busy;
  assign busy_v[1] = if_b.busy;
  assign busy_v[2] = if_c.busy;

  function automatic bit is_elig(input int k, input int i);
    return req[k[1:0]][i[3:0]] && (int'(addr[k[1:0]][i[3:0]]) == ms[k[1:0]]);
  endfunction

  function automatic int scan(input int k, input int start, input int skip);
    for (int j = 0; j < mn[k[1:0]]; j++) begin
      int i;
      i = (start + j) % mn[k[1:0]];
      if (i != skip && is_elig(k, i)) return i;
    end
    return -1;
  endfunction

  // Model state: granted master (0-based, -1 none), rotation pointer, acks consumed in this grant.
  function automatic void model_next(input int k, output int g, output int p, output int c);
    int cg;
    cg = mg[k[1:0]];
    g  = cg;
    p  = mp[k[1:0]];
    c  = mc[k[1:0]];
    if (cg < 0) begin
      g = scan(k, p, -1);
      c = 0;
    end else if (!is_elig(k, cg)) begin
      p = (cg + 1) % mn[k[1:0]];
      g = -1;
      c = 0;
    end else if (ack[k[1:0]]) begin
      if (c + 1 < mb[k[1:0]]) begin
        c = c + 1;
      end else begin
        p = (cg + 1) % mn[k[1:0]];
        g = scan(k, p, cg);
        if (g < 0) g = cg;
        c = 0;
      end
    end
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ng[k[1:0]] = -1;
      np[k[1:0]] = 0;
      nc[k[1:0]] = 0;
      model_next(k, ng[k[1:0]], np[k[1:0]], nc[k[1:0]]);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        mg[k[1:0]] <= -1;
        mp[k[1:0]] <= 0;
        mc[k[1:0]] <= 0;
      end else begin
        mg[k[1:0]] <= ng[k[1:0]];
        mp[k[1:0]] <= np[k[1:0]];
        mc[k[1:0]] <= nc[k[1:0]];
      end
    end
  end

  task automatic chk(input string name, input int k, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic compare_inst(input int k);
    int g, e_nme, e_sreq, e_mack, e_busy;
    g      = mg[k[1:0]];
    e_busy = (g >= 0) ? 1 : 0;
    e_nme  = (g >= 0) ? g + 1 : 0;
    e_sreq = (g >= 0 && is_elig(k, g)) ? 1 : 0;
    e_mack = (e_sreq == 1 && ack[k[1:0]]) ? (1 << g) : 0;
    chk("model.number_master_en", k, nme_v[k[1:0]], e_nme);
    chk("model.slave_req", k, int'(sreq_v[k[1:0]]), e_sreq);
    chk("model.master_ack", k, int'(mack_v[k[1:0]]), e_mack);
    chk("model.busy", k, int'(busy_v[k[1:0]]), e_busy);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) compare_inst(k);
  end

  task automatic check_out(input string name, input int k, input int nme_e, input int sreq_e,
                           input int mack_e);
    chk({name, ".nme"}, k, nme_v[k[1:0]], nme_e);
    chk({name, ".slave_req"}, k, int'(sreq_v[k[1:0]]), sreq_e);
    chk({name, ".master_ack"}, k, int'(mack_v[k[1:0]]), mack_e);
    chk({name, ".busy"}, k, int'(busy_v[k[1:0]]), (nme_e != 0) ? 1 : 0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      req[k[1:0]] = '0;
      ack[k[1:0]] = 1'b0;
      for (int i = 0; i < 16; i++) addr[k[1:0]][i[3:0]] = '0;
    end
  endtask

  task automatic do_reset();
    next_cyc();
    reset_n = 1'b0;
    clear_inputs();
    next_cyc();
    next_cyc();
    reset_n = 1'b1;
  endtask

  int seq4 [7] = '{1, 1, 1, 4, 4, 4, 1};

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      req[k[1:0]] = 16'hFFFF;
      ack[k[1:0]] = 1'b1;
      for (int i = 0; i < 16; i++) addr[k[1:0]][i[3:0]] = 4'(ms[k[1:0]]);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_out("reset", k, 0, 0, 0);

    // Single request, ack, release
    do_reset();
    req[0] = 16'b0100;
    @(negedge clk) check_out("t1_idle", 0, 0, 0, 0);
    next_cyc();
    ack[0] = 1'b1;
    @(negedge clk) check_out("t1_ack", 0, 3, 1, 4);
    next_cyc();
    ack[0] = 1'b0;
    req[0] = '0;
    @(negedge clk) check_out("t1_drop", 0, 3, 0, 0);
    next_cyc();
    @(negedge clk) check_out("t1_idle2", 0, 0, 0, 0);

    // Fair rotation with everyone requesting
    do_reset();
    req[0] = 16'hF;
    ack[0] = 1'b1;
    @(negedge clk) check_out("t2_idle", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) check_out("t2_order", 0, (i % 4) + 1, 1, 1 << (i % 4));
    end

    // Address filtering
    do_reset();
    req[0]     = 16'b0011;
    addr[0][1] = 4'd1;
    ack[0]     = 1'b1;
    @(negedge clk) check_out("t3_idle", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check_out("t3_m1", 0, 1, 1, 1);
    end
    next_cyc();
    addr[0][1] = 4'd0;
    @(negedge clk) check_out("t3_m1_last", 0, 1, 1, 1);
    @(negedge clk) check_out("t3_m2", 0, 2, 1, 2);

    // Burst quota of three
    do_reset();
    req[1] = 16'b1001;
    ack[1] = 1'b1;
    @(negedge clk) check_out("t4_idle", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) check_out("t4_burst", 1, seq4[i], 1, 1 << (seq4[i] - 1));
    end

    // Request withdrawn before ack
    do_reset();
    req[0] = 16'b0010;
    @(negedge clk) check_out("t5_idle", 0, 0, 0, 0);
    @(negedge clk) check_out("t5_grant", 0, 2, 1, 0);
    next_cyc();
    req[0] = '0;
    ack[0] = 1'b1;
    @(negedge clk) check_out("t5_drop", 0, 2, 0, 0);
    next_cyc();
    ack[0] = 1'b0;
    req[0] = 16'b0101;
    @(negedge clk) check_out("t5_released", 0, 0, 0, 0);
    @(negedge clk) check_out("t5_m3", 0, 3, 1, 0);

    // Five masters: wrap, then asynchronous reset mid-grant
    do_reset();
    for (int i = 0; i < 5; i++) addr[2][i[3:0]] = 4'd5;
    req[2] = 16'h1F;
    ack[2] = 1'b1;
    @(negedge clk) check_out("t6_idle", 2, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) check_out("t6_wrap", 2, (i % 5) + 1, 1, 1 << (i % 5));
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_out("t6_async", 2, 0, 0, 0);
    next_cyc();
    reset_n = 1'b1;
    @(negedge clk) check_out("t6_restart_idle", 2, 0, 0, 0);
    @(negedge clk) check_out("t6_restart", 2, 1, 1, 1);

    // Randomized traffic on all three instances
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      next_cyc();
      if (cyc == 900) reset_n = 1'b0;
      if (cyc == 903) reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < mn[k[1:0]]; i++) begin
          if ($urandom_range(0, 4) == 0) req[k[1:0]][i[3:0]] = ~req[k[1:0]][i[3:0]];
          if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) addr[k[1:0]][i[3:0]] = 4'(ms[k[1:0]]);
            else addr[k[1:0]][i[3:0]] = 4'($urandom_range(0, (1 << maw[k[1:0]]) - 1));
          end
        end
        ack[k[1:0]] = ($urandom_range(0, 2) != 0);
      end
    end

    next_cyc();
    clear_inputs();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
